// File: rtl/vx_stream_packet_switch.sv
// Packet-aware stream crossbar. Each input routes whole packets to one output.
// Each output arbitrates round-robin between packets and stays locked to one
// input until that input's last beat. OUT_BUF selects a combinational output
// path (0) or a 2-entry registered buffer per output (1).
//
// Per-input packet FSM:
//   state   | meaning
//   IN_IDLE | between packets; beats are routed by the live sel_in
//   IN_BUSY | inside a packet; beats follow the destination latched on beat 0
module vx_stream_packet_switch #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_OUTPUTS = 4,
  parameter int DATAW       = 32,
  parameter int OUT_BUF     = 1,
  localparam int DSTW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1,
  localparam int SRCW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_INPUTS-1:0]               valid_in,
  input  logic [NUM_INPUTS-1:0][DATAW-1:0]    data_in,
  input  logic [NUM_INPUTS-1:0]               last_in,
  input  logic [NUM_INPUTS-1:0][DSTW-1:0]     sel_in,
  output logic [NUM_INPUTS-1:0]               ready_in,
  output logic [NUM_OUTPUTS-1:0]              valid_out,
  output logic [NUM_OUTPUTS-1:0][DATAW-1:0]   data_out,
  output logic [NUM_OUTPUTS-1:0]              last_out,
  output logic [NUM_OUTPUTS-1:0][SRCW-1:0]    src_out,
  input  logic [NUM_OUTPUTS-1:0]              ready_out
);

  typedef enum logic {
    IN_IDLE = 1'b0,
    IN_BUSY = 1'b1
  } in_state_e;

  // Input-side packet state
  in_state_e           in_state_q [NUM_INPUTS];
  in_state_e           in_state_d [NUM_INPUTS];
  logic [DSTW-1:0]     in_dst_q   [NUM_INPUTS];
  logic [DSTW-1:0]     in_dst_d   [NUM_INPUTS];

  // Output-side lock / owner / round-robin pointer
  logic [NUM_OUTPUTS-1:0] lock_q, lock_d;
  logic [SRCW-1:0]        owner_q [NUM_OUTPUTS];
  logic [SRCW-1:0]        owner_d [NUM_OUTPUTS];
  logic [SRCW-1:0]        ptr_q   [NUM_OUTPUTS];
  logic [SRCW-1:0]        ptr_d   [NUM_OUTPUTS];

  // Routing and arbitration results
  logic [DSTW-1:0]        eff_dst [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]  drop;
  logic [NUM_INPUTS-1:0]  req     [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0] gnt_vld;
  logic [SRCW-1:0]        gnt_idx [NUM_OUTPUTS];
  logic [DATAW-1:0]       win_data [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0] win_last;
  logic [NUM_OUTPUTS-1:0] os_rdy;
  logic [NUM_OUTPUTS-1:0] xfer;

  // Destination of each input and its per-output request vector; a beat from
  // an idle input aimed past the last output is swallowed without routing.
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      eff_dst[i] = (in_state_q[i] == IN_BUSY) ? in_dst_q[i] : sel_in[i];
      drop[i]    = valid_in[i] && (in_state_q[i] == IN_IDLE)
                   && (int'(sel_in[i]) >= NUM_OUTPUTS);
    end
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      req[o] = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        req[o][i] = valid_in[i] && !drop[i] && (int'(eff_dst[i]) == o);
      end
    end
  end

  // Per-output grant: owner only while locked, otherwise first requester at or
  // after the priority pointer. The descending loop lets the lowest offset win.
  always_comb begin
    int idx;
    idx = 0;
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      gnt_vld[o] = 1'b0;
      gnt_idx[o] = '0;
      if (lock_q[o]) begin
        if (req[o][owner_q[o]]) begin
          gnt_vld[o] = 1'b1;
          gnt_idx[o] = owner_q[o];
        end
      end else begin
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
          idx = (int'(ptr_q[o]) + k) % NUM_INPUTS;
          if (req[o][idx]) begin
            gnt_vld[o] = 1'b1;
            gnt_idx[o] = SRCW'(idx);
          end
        end
      end
    end
  end

  // Winner payload mux and the transfer strobe into the output stage
  always_comb begin
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      win_data[o] = data_in[gnt_idx[o]];
      win_last[o] = last_in[gnt_idx[o]];
      xfer[o]     = gnt_vld[o] && os_rdy[o];
    end
  end

  // Input ready: granted and output stage can take it, or a dropped beat.
  // Held low throughout reset.
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      ready_in[i] = drop[i];
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        if (gnt_vld[o] && os_rdy[o] && (gnt_idx[o] == SRCW'(i))) begin
          ready_in[i] = 1'b1;
        end
      end
      ready_in[i] = ready_in[i] && reset;
    end
  end

  // Next-state for input packet FSMs and output lock/pointer registers
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      in_state_d[i] = in_state_q[i];
      in_dst_d[i]   = in_dst_q[i];
      if (valid_in[i] && ready_in[i] && !drop[i]) begin
        case (in_state_q[i])
          IN_IDLE: begin
            if (!last_in[i]) begin
              in_state_d[i] = IN_BUSY;
              in_dst_d[i]   = sel_in[i];
            end
          end
          IN_BUSY: begin
            if (last_in[i]) begin
              in_state_d[i] = IN_IDLE;
            end
          end
          default: in_state_d[i] = IN_IDLE;
        endcase
      end
    end
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      lock_d[o]  = lock_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      if (xfer[o]) begin
        if (win_last[o]) begin
          lock_d[o] = 1'b0;
          ptr_d[o]  = (int'(gnt_idx[o]) == NUM_INPUTS - 1) ? '0
                                                            : gnt_idx[o] + SRCW'(1);
        end else begin
          lock_d[o]  = 1'b1;
          owner_d[o] = gnt_idx[o];
        end
      end
    end
  end

  // State registers; reset drops any packet in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        in_state_q[i] <= IN_IDLE;
        in_dst_q[i]   <= '0;
      end
      lock_q <= '0;
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        in_state_q[i] <= in_state_d[i];
        in_dst_q[i]   <= in_dst_d[i];
      end
      lock_q <= lock_d;
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

  if (OUT_BUF != 0) begin : g_buf
    for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_out
      logic [DATAW-1:0] mem_data [2];
      logic [SRCW-1:0]  mem_src  [2];
      logic [1:0]       mem_last;
      logic             wr_ptr;
      logic             rd_ptr;
      logic [1:0]       count;
      logic             push;
      logic             pop;

      // Two entries let the buffer accept every cycle under continuous ready
      assign os_rdy[o]    = (count != 2'd2);
      assign push         = xfer[o];
      assign pop          = valid_out[o] && ready_out[o];
      assign valid_out[o] = reset && (count != 2'd0);
      assign data_out[o]  = mem_data[rd_ptr];
      assign last_out[o]  = mem_last[rd_ptr];
      assign src_out[o]   = mem_src[rd_ptr];

      // Occupancy and pointers
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          count  <= 2'd0;
          wr_ptr <= 1'b0;
          rd_ptr <= 1'b0;
        end else begin
          if (push) wr_ptr <= ~wr_ptr;
          if (pop)  rd_ptr <= ~rd_ptr;
          case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
          endcase
        end
      end

      // Payload storage; contents are don't-care while empty
      always_ff @(posedge clk) begin
        if (push) begin
          mem_data[wr_ptr] <= win_data[o];
          mem_last[wr_ptr] <= win_last[o];
          mem_src[wr_ptr]  <= gnt_idx[o];
        end
      end
    end
  end else begin : g_nobuf
    for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_out
      assign os_rdy[o]    = ready_out[o];
      assign valid_out[o] = reset && gnt_vld[o];
      assign data_out[o]  = win_data[o];
      assign last_out[o]  = win_last[o];
      assign src_out[o]   = gnt_idx[o];
    end
  end

endmodule
